btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Cleans one raw push-button input from the board KEY pins before it reaches the counter and display logic.
- Pipeline: 2-flop synchronizer → polarity normalize → counter-based debounce → event FSM.
- Outputs a clean debounced level plus single-cycle press and release pulses; these feed the edge inputs of the up/down counter.
- One instance per button.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles the input must hold a new value before it is accepted (20 ms at 50 MHz); legal range ≥1.
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = raw pin reads 1 when pressed.
- REPEAT_DELAY, 25000000, hold time in cycles from press pulse to first auto-repeat pulse (500 ms); used only with the optional feature.
- REPEAT_RATE, 5000000, cycles between later auto-repeat pulses (100 ms); used only with the optional feature.

Ports:
- CLK_50  in  1  50 MHz system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  1  asynchronous raw pin; polarity set by ACTIVE_LOW.
- btn_level  out  1  debounced level; 1 = pressed.
- press_pulse  out  1  one-cycle pulse on an accepted press, and on each auto-repeat.
- release_pulse  out  1  one-cycle pulse on an accepted release.

Behaviour:
- Reset: btn_level=0, press_pulse=0, release_pulse=0, debounce and repeat counters=0, FSM=IDLE.
  - Synchronizer flops reset to the released level (1 if ACTIVE_LOW, else 0).
- Synchronizer: sync1 <= btn_raw; sync2 <= sync1. pressed_s = sync2 XOR ACTIVE_LOW.
- Debounce, each edge:
  - If pressed_s == btn_level: counter clears to 0.
  - Else if counter == DEBOUNCE_CYCLES-1: btn_level <= pressed_s; counter clears.
  - Else: counter increments.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); it never wraps.
- Latency: edge 0 is the first edge that samples the new btn_raw value. btn_level updates at edge DEBOUNCE_CYCLES+1 if the raw value is held throughout.
- Glitch rejection: any return to the old value before acceptance clears the counter and leaves btn_level unchanged. A bounce restarts the full DEBOUNCE_CYCLES window.
- FSM states: IDLE, HELD, plus REPEAT with the optional feature. All pulse outputs are registered and default to 0 every cycle.
  - IDLE → HELD on the edge where btn_level goes 0→1. press_pulse=1 for that same cycle, aligned with the btn_level rise.
  - HELD/REPEAT → IDLE on the edge where btn_level goes 1→0. release_pulse=1 for that cycle; the repeat counter clears.
- press_pulse and release_pulse are never high in the same cycle.
- Reset mid-operation:
  - All state returns to reset values. No release_pulse is emitted.
  - A button still held when reset deasserts is accepted as a new press DEBOUNCE_CYCLES+2 edges after the first edge without reset, because the synchronizer refills from the released level.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - In HELD, the repeat counter counts cycles since the press pulse. When REPEAT_DELAY cycles have elapsed, press_pulse=1 for one cycle and FSM → REPEAT.
  - In REPEAT, press_pulse=1 every REPEAT_RATE cycles while held.
  - Repeat counter width is $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1). It restarts from 0 on each emitted pulse.
  - A release in the same cycle a repeat would fire: the release wins and no press_pulse is emitted.
- Undefined:
  - No repeat counter or REPEAT state is synthesized; the REPEAT_* parameters are ignored.
  - Exactly one press_pulse per accepted press, however long the button is held.

Test Plan:
All directed scenarios use DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_RATE=3.
1. Reset held 3 cycles, btn_raw=1 → btn_level=0, both pulses 0 throughout and after reset release.
2. btn_raw 1→0 held, first sampled at edge 0 → btn_level=1 and press_pulse=1 at edge 5; press_pulse=0 at edge 6.
3. btn_raw low for 3 cycles then high again (glitch) → btn_level stays 0, no pulses. Then low 4+ cycles → press accepted 5 edges after the final falling sample.
4. Press accepted, then btn_raw released and held → release_pulse=1 exactly once, 5 edges after the first high sample; btn_level=0 on the same edge.
5. With BTN_AUTO_REPEAT_EN, press at edge P held 20 cycles → press_pulse at P, P+10, P+13, P+16, P+19. Without the macro → pulse at P only.
6. Button held, reset asserted 2 cycles then deasserted with btn_raw still 0 → no release_pulse. press_pulse at the 6th edge after reset deasserts.

Source files
------------

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Purpose:
//   Conditions one raw push-button pin from the board KEY inputs. The raw pin
//   is brought into the CLK_50 domain through a 2-flop synchronizer. Its
//   polarity is normalized so that 1 means pressed. It is then debounced with
//   a hold counter. Finally an event FSM turns the clean level into
//   single-cycle press/release pulses for the up/down counter edge inputs.
//   Use one instance per button.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive cycles a new input value must be held before
//                     it is accepted (>= 1)
//   ACTIVE_LOW      - 1: pin reads 0 when pressed; 0: pin reads 1 when pressed
//   REPEAT_DELAY    - cycles from the press pulse to the first auto-repeat pulse
//   REPEAT_RATE     - cycles between later auto-repeat pulses
//
// Optional feature:
//   Define BTN_AUTO_REPEAT_EN to enable auto-repeat press pulses while the
//   button is held. Without it there is no repeat counter and no REPEAT state,
//   and each accepted press gives exactly one press_pulse.
//
// Ports:
//   CLK_50        in  50 MHz system clock, rising edge
//   reset         in  synchronous, active-high reset
//   btn_raw       in  asynchronous raw button pin
//   btn_level     out debounced level, 1 = pressed
//   press_pulse   out one-cycle pulse on accepted press (and each auto-repeat)
//   release_pulse out one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic CLK_50,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Stage 0: two-flop synchronizer
  // ---------------------------------------------------------------------------
  // Both flops reset to the released pin level. A button held through reset
  // is therefore seen as a fresh press once reset deasserts.
  logic r_sync1;
  logic r_sync2;
  logic w_pressed;

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = r_sync2 ^ ACTIVE_LOW;

  // ---------------------------------------------------------------------------
  // Stage 1: counter-based debounce
  // ---------------------------------------------------------------------------
  // The counter runs only while the synchronized input disagrees with the
  // accepted level. Any agreement clears it, so a bounce restarts the full
  // window. The counter stops at DB_LAST, so it can never wrap.
  logic [DB_W-1:0] r_db_cnt;
  logic            r_level;
  logic            w_differ;
  logic            w_accept;
  logic            w_rise;
  logic            w_fall;

  assign w_differ = (w_pressed != r_level);
  assign w_accept = w_differ && (r_db_cnt == DB_LAST);
  assign w_rise   = w_accept &&  w_pressed;
  assign w_fall   = w_accept && !w_pressed;

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else if (!w_differ) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_level  <= w_pressed;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: event FSM
  // ---------------------------------------------------------------------------
  // The FSM reacts to the debounce accept strobes rather than to r_level.
  // This registers each pulse on the same edge that btn_level changes.
`ifdef BTN_AUTO_REPEAT_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HELD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  localparam int              RP_MAX        = (REPEAT_DELAY > REPEAT_RATE) ?
                                              REPEAT_DELAY : REPEAT_RATE;
  localparam int              RP_W          = $clog2(RP_MAX + 1);
  localparam logic [RP_W-1:0] RP_DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_RATE_LAST  = RP_W'(REPEAT_RATE - 1);

  logic [RP_W-1:0] r_rep_cnt;
  logic [RP_W-1:0] w_rep_cnt_next;
`else
  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_t;

  // The repeat parameters only matter for the auto-repeat build.
  logic w_unused_repeat;
  assign w_unused_repeat = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  state_t r_state;
  state_t w_state_next;
  logic   r_press;
  logic   r_release;
  logic   w_press_next;
  logic   w_release_next;

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_press   <= 1'b0;
      r_release <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      r_rep_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
`ifdef BTN_AUTO_REPEAT_EN
      r_rep_cnt <= w_rep_cnt_next;
`endif
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    w_rep_cnt_next = r_rep_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_next = S_HELD;
          w_press_next = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
          w_rep_cnt_next = '0;
`endif
        end
      end
      S_HELD: begin
        // A release takes priority over a repeat that is due on the same edge.
        if (w_fall) begin
          w_state_next   = S_IDLE;
          w_release_next = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
          w_rep_cnt_next = '0;
        end else if (r_rep_cnt == RP_DELAY_LAST) begin
          w_state_next   = S_REPEAT;
          w_press_next   = 1'b1;
          w_rep_cnt_next = '0;
        end else begin
          w_rep_cnt_next = r_rep_cnt + RP_W'(1);
`endif
        end
      end
`ifdef BTN_AUTO_REPEAT_EN
      S_REPEAT: begin
        if (w_fall) begin
          w_state_next   = S_IDLE;
          w_release_next = 1'b1;
          w_rep_cnt_next = '0;
        end else if (r_rep_cnt == RP_RATE_LAST) begin
          w_press_next   = 1'b1;
          w_rep_cnt_next = '0;
        end else begin
          w_rep_cnt_next = r_rep_cnt + RP_W'(1);
        end
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

endmodule
